uart_tx_param: RTL and testbench

Parametrised UART transmitter with a write-side FIFO. It is the successor to the fixed 8N1/9600 transmitter on the Micro80 serial port. Frame format (data bits, parity, stop bits), the clock/baud ratio and the buffer depth are all set by parameters. The CPU I/O port writes bytes into the FIFO and the block sends them back-to-back on `tx` with no gap between frames.

---
 rtl/uart_tx_param.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a write-side FIFO.
// Frames are sent back-to-back on tx; tx is registered one cycle behind the FSM state.
module uart_tx_param #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               DIN,
    output logic                     tx,
    output logic                     bsy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);
    localparam int UBRR  = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(UBRR);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(UBRR - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    function automatic logic [7:0] mask_data(input logic [7:0] d);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < DATA_BITS) ? d[i] : 1'b0;
        end
        return m;
    endfunction

    // Odd mode makes the total count of ones odd, even mode makes it even.
    function automatic logic parity_bit(input logic [7:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [2:0]            bit_r, bit_s;
    logic                  stop_r, stop_s;
    logic [7:0]            shift_r, shift_s;
    logic                  par_r, par_s;
    logic                  pop_s, tx_s, wr_s, bit_end_s, fifo_ne_s;
    logic [7:0]            head_s;
    logic [7:0]            mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]      level_r, level_s;
    logic                  full_r, ovf_r, tx_r, bsy_r;

    assign wr_s      = start && !full_r;
    assign head_s    = mask_data(mem_r[rd_ptr_r]);
    assign bit_end_s = (cnt_r == {CNT_W{1'b0}});
    assign fifo_ne_s = (level_r != {LVL_W{1'b0}});
    assign level_s   = LVL_W'(level_r + LVL_W'(wr_s) - LVL_W'(pop_s));

    // Next-state, bit timing, shift register and line value.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        stop_s  = stop_r;
        shift_s = shift_r;
        par_s   = par_r;
        pop_s   = 1'b0;
        tx_s    = 1'b1;
        case (state_r)
            IDLE: begin
                tx_s = 1'b1;
                if (fifo_ne_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    par_s   = parity_bit(head_s);
                    cnt_s   = RELOAD;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                tx_s = 1'b0;
                if (bit_end_s) begin
                    cnt_s   = RELOAD;
                    bit_s   = 3'd0;
                    state_s = DATA;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DATA: begin
                tx_s = shift_r[0];
                if (bit_end_s) begin
                    cnt_s   = RELOAD;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'(DATA_BITS - 1)) begin
                        stop_s  = 1'b0;
                        state_s = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            PAR: begin
                tx_s = par_r;
                if (bit_end_s) begin
                    cnt_s   = RELOAD;
                    stop_s  = 1'b0;
                    state_s = STOP;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            STOP: begin
                tx_s = 1'b1;
                if (bit_end_s) begin
                    cnt_s = RELOAD;
                    if (stop_r == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when data is waiting.
                        if (fifo_ne_s) begin
                            pop_s   = 1'b1;
                            shift_s = head_s;
                            par_s   = parity_bit(head_s);
                            state_s = START;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        stop_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            bit_r   <= 3'd0;
            stop_r  <= 1'b0;
            shift_r <= 8'd0;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            stop_r  <= stop_s;
            shift_r <= shift_s;
            par_r   <= par_s;
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= DIN;
        end
    end

    // FIFO pointers, occupancy and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            tx_r     <= 1'b1;
            bsy_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_s  ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            level_r  <= level_s;
            full_r   <= (level_s == LVL_W'(DEPTH));
            ovf_r    <= ovf_r | (start & full_r);
            tx_r     <= tx_s;
            bsy_r    <= (state_s != IDLE) || (level_s != {LVL_W{1'b0}});
        end
    end

    assign tx    = tx_r;
    assign bsy   = bsy_r;
    assign full  = full_r;
    assign level = level_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four frame formats at UBRR=10, burst/overflow,
// write on the popping edge at full, and reset mid-frame.
module tb_uart_tx_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_v [4];
    logic [7:0] din_v   [4];
    logic       tx_v    [4];
    logic       bsy_v   [4];
    logic       full_v  [4];
    logic [2:0] level_v [4];
    logic       ovf_v   [4];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .DIN(din_v[0]), .tx(tx_v[0]),
        .bsy(bsy_v[0]), .full(full_v[0]), .level(level_v[0]), .ovf(ovf_v[0]));
    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .DIN(din_v[1]), .tx(tx_v[1]),
        .bsy(bsy_v[1]), .full(full_v[1]), .level(level_v[1]), .ovf(ovf_v[1]));
    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .DIN(din_v[2]), .tx(tx_v[2]),
        .bsy(bsy_v[2]), .full(full_v[2]), .level(level_v[2]), .ovf(ovf_v[2]));
    uart_tx_param #(.CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .start(start_v[3]), .DIN(din_v[3]), .tx(tx_v[3]),
        .bsy(bsy_v[3]), .full(full_v[3]), .level(level_v[3]), .ovf(ovf_v[3]));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line bits of one frame, index 0 = start bit; everything past the frame reads 1.
    function automatic logic [63:0] build_frame(input logic [7:0] d, input int nb, input int hp,
                                                input logic pb);
        logic [63:0] f;
        int p;
        f = 64'hFFFF_FFFF_FFFF_FFFF;
        f[0] = 1'b0;
        p = 1;
        for (int i = 0; i < nb; i++) begin
            f[p] = d[i];
            p++;
        end
        if (hp != 0) begin
            f[p] = pb;
        end
        return f;
    endfunction

    // Called at the negedge holding the first start-bit sample; leaves at the last sample.
    task automatic sample_stream(input int idx, input logic [63:0] exp_v, input int nbits,
                                 input string tag);
        int   errs;
        int   s;
        logic bsy_pen;
        bsy_pen = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            errs = 0;
            for (int c = 0; c < 10; c++) begin
                s = b * 10 + c;
                if (tx_v[idx] !== exp_v[b]) errs++;
                if (s == nbits * 10 - 2) bsy_pen = bsy_v[idx];
                if (s == nbits * 10 - 1) begin
                    check_eq($sformatf("%s bsy_end", tag), 32'(bsy_v[idx]), 32'd0);
                end else begin
                    @(negedge clk);
                end
            end
            check_eq($sformatf("%s bit%0d_wrong_samples", tag, b), 32'(errs), 32'd0);
        end
        check_eq($sformatf("%s bsy_before_end", tag), 32'(bsy_pen), 32'd1);
    endtask

    task automatic run_frame(input int idx, input logic [7:0] data, input int nb, input int hp,
                             input logic pb, input int ns, input string tag);
        @(negedge clk);
        start_v[idx] = 1'b1;
        din_v[idx]   = data;
        @(negedge clk);
        start_v[idx] = 1'b0;
        check_eq({tag, " level_after_write"}, 32'(level_v[idx]), 32'd1);
        check_eq({tag, " bsy_after_write"}, 32'(bsy_v[idx]), 32'd1);
        @(negedge clk);
        check_eq({tag, " tx_still_idle"}, 32'(tx_v[idx]), 32'd1);
        check_eq({tag, " level_after_pop"}, 32'(level_v[idx]), 32'd0);
        @(negedge clk);
        sample_stream(idx, build_frame(data, nb, hp, pb), 1 + nb + hp + ns, tag);
        repeat (3) @(negedge clk);
        check_eq({tag, " tx_idle_after"}, 32'(tx_v[idx]), 32'd1);
    endtask

    logic [7:0]  burst   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [2:0]  lvl_exp [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic        ful_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        ovf_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [63:0] stream;
        logic [63:0] f;
        int          errs;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            din_v[i]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_eq("rst tx", 32'(tx_v[0]), 32'd1);
        check_eq("rst bsy", 32'(bsy_v[0]), 32'd0);
        check_eq("rst full", 32'(full_v[0]), 32'd0);
        check_eq("rst level", 32'(level_v[0]), 32'd0);
        check_eq("rst ovf", 32'(ovf_v[0]), 32'd0);
        rst = 1'b0;

        run_frame(0, 8'h55, 8, 0, 1'b0, 1, "8N1_55");
        run_frame(1, 8'hA5, 8, 1, 1'b0, 1, "8E1_A5");
        run_frame(2, 8'hA5, 8, 1, 1'b1, 1, "8O1_A5");
        run_frame(1, 8'h07, 8, 1, 1'b1, 1, "8E1_07");
        run_frame(2, 8'h07, 8, 1, 1'b0, 1, "8O1_07");
        run_frame(3, 8'hFF, 7, 0, 1'b0, 2, "7N2_FF");

        // Six writes on consecutive cycles: five accepted, sixth dropped, five contiguous frames.
        stream = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            f = build_frame(burst[i], 8, 0, 1'b0);
            stream[i*10 +: 10] = f[9:0];
        end
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    start_v[0] = 1'b1;
                    din_v[0]   = burst[i];
                    @(negedge clk);
                    check_eq($sformatf("burst level%0d", i), 32'(level_v[0]), 32'(lvl_exp[i]));
                    check_eq($sformatf("burst full%0d", i), 32'(full_v[0]), 32'(ful_exp[i]));
                    check_eq($sformatf("burst ovf%0d", i), 32'(ovf_v[0]), 32'(ovf_exp[i]));
                end
                start_v[0] = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                sample_stream(0, stream, 50, "burst");
            end
        join
        @(negedge clk);
        check_eq("burst ovf_sticky", 32'(ovf_v[0]), 32'd1);
        check_eq("burst level_end", 32'(level_v[0]), 32'd0);

        // Clear ovf, refill to full, then write on the edge where STOP->START pops.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst2 ovf", 32'(ovf_v[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start_v[0] = 1'b1;
            din_v[0]   = burst[i];
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        repeat (96) @(negedge clk);
        check_eq("simul level_pre", 32'(level_v[0]), 32'd4);
        check_eq("simul full_pre", 32'(full_v[0]), 32'd1);
        check_eq("simul ovf_pre", 32'(ovf_v[0]), 32'd0);
        start_v[0] = 1'b1;
        din_v[0]   = 8'h99;
        @(negedge clk);
        start_v[0] = 1'b0;
        check_eq("simul level_post", 32'(level_v[0]), 32'd3);
        check_eq("simul full_post", 32'(full_v[0]), 32'd0);
        check_eq("simul ovf_post", 32'(ovf_v[0]), 32'd1);
        check_eq("simul tx_stop", 32'(tx_v[0]), 32'd1);
        @(negedge clk);
        check_eq("simul tx_next_start", 32'(tx_v[0]), 32'd0);

        // Reset while the start bit is on the line.
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst tx", 32'(tx_v[0]), 32'd1);
        check_eq("midrst bsy", 32'(bsy_v[0]), 32'd0);
        check_eq("midrst level", 32'(level_v[0]), 32'd0);
        check_eq("midrst full", 32'(full_v[0]), 32'd0);
        check_eq("midrst ovf", 32'(ovf_v[0]), 32'd0);
        rst = 1'b0;
        errs = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || bsy_v[0] !== 1'b0) errs++;
        end
        check_eq("midrst quiet_line", 32'(errs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
